rr_grant_ctrl: RTL and testbench
================================

# rr_grant_ctrl

Round-robin grant controller that shares one sequential resource, such as a pattern-detector FSM or a shared datapath stage, among N requesters. It is a registered Moore machine: every grant output is a pure function of the state registers, and the block never drives a combinational path from `req` to `gnt`. It sits between the requesting blocks and the shared resource's enable/select inputs.

## Interface
- `N`, default 4: number of requesters; must be at least 2.
- `MAX_HOLD`, default 8: maximum number of consecutive grant cycles per owner. Used only when the timeout feature is compiled in. Must be at least 2.
- `IDW`, default 2: width of `gnt_id`; must equal clog2(N).

Ports:
- `clk`  input  1: the single clock; all state changes on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `req`  input  N: request vector; bit i is requester i.
- `done`  input  1: the current owner releases the resource; sampled only in state GRANT.
- `gnt`  output  N: registered one-hot grant; all zeros when no owner.
- `gnt_id`  output  IDW: index of the current owner; holds the last owner when idle.
- `busy`  output  1: high while in state GRANT.
- `preempt`  output  1: one-cycle pulse on the cycle following a timeout release.

## Operation
- States: IDLE (2'b00), GRANT (2'b01). Encodings 2'b10 and 2'b11 are illegal and go to IDLE on the next edge.
- Registers:
  - `state`.
  - `ptr` (IDW bits): highest-priority index for the next arbitration.
  - `owner` (IDW bits).
  - `hold_cnt`: exists only when the timeout feature is compiled in.
- IDLE:
  - If `req` is nonzero, select the first set bit scanning `ptr`, `ptr`+1, and onward, wrapping modulo N.
  - On the selection: `owner` = winner, `ptr` = (winner + 1) mod N, and the state goes to GRANT.
  - If `req` is zero, remain in IDLE.
- GRANT:
  - Release condition: `done` = 1, or `req[owner]` = 0, or a timeout occurs (feature only).
  - On release, the state goes to IDLE.
  - Otherwise, remain in GRANT.
  - Requests from non-owners are ignored while in GRANT.
- Outputs, all decoded from registers:
  - `gnt` = one-hot(`owner`) in GRANT, otherwise 0.
  - `busy` = 1 exactly in GRANT.
  - `gnt_id` = `owner`.
- Simultaneous events:
  - `done` together with `req[owner]` dropping counts as a single release.
  - Timeout together with `done` is treated as a normal release, so `preempt` stays 0.
- Wrap-around: `ptr` goes from N-1 to 0.
- Fairness: a requester that holds `req` high is granted within N arbitrations.

## Timing
- Reset, synchronous, takes effect at the edge where `reset` = 1. Values after that edge:
  - `state` = IDLE, `ptr` = 0, `owner` = 0, `hold_cnt` = 0.
  - `gnt` = 0, `gnt_id` = 0, `busy` = 0, `preempt` = 0.
- Reset takes priority over every other event. A reset asserted mid-GRANT clears `gnt` after that edge, with no `preempt` pulse.
- Grant latency: `req` first sampled high at edge t (in IDLE) gives `gnt` valid after edge t. The earliest grant is one cycle after `req` is driven.
- Release: a release condition sampled at edge t gives `gnt` = 0 after edge t.
- Turnaround: the next arbitration happens at edge t+1, so there is exactly one idle cycle (`gnt` = 0) between consecutive owners.
- Owner continuity: `gnt` holds steady for the entire GRANT interval. The minimum grant length is 1 cycle, which occurs when `done` = 1 at the first edge.

## Configuration
- Macro: `RR_GRANT_CTRL_TIMEOUT_EN`.
- Defined:
  - `hold_cnt` (clog2(MAX_HOLD) bits) is cleared when entering GRANT and increments each GRANT cycle.
  - When `hold_cnt` = MAX_HOLD-1 and no other release condition is present, the edge forces a release to IDLE. `preempt` is 1 for the following cycle.
  - The maximum grant length is therefore MAX_HOLD cycles.
- Undefined:
  - No counter is built and `preempt` is tied to 0.
  - A grant lasts until `done` or until `req[owner]` drops.

## Test plan
Parameters: N=4, MAX_HOLD=8.
- Reset: hold `reset` = 1 with `req` = 4'b1111 → after the edge `gnt` = 0, `busy` = 0, `gnt_id` = 0. Release reset → `gnt` = 4'b0001 after the next edge.
- Rotation: `req` = 4'b1111, with `done` pulsed one cycle after each grant → `gnt` sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
- Pointer skip and wrap: `ptr` = 3, `req` = 4'b0101 → `gnt` = 0001 and `ptr` becomes 1. Next arbitration → `gnt` = 0100.
- Non-owner ignored: owner 1 held for 5 cycles while `req[2]` toggles → `gnt` stays 0010. Owner drops `req[1]` → `gnt` = 0 after 1 edge, then 0100.
- Timeout (macro defined): `req` = 4'b0001, `done` = 0 → `gnt` = 0001 for exactly 8 cycles, then `gnt` = 0 with `preempt` = 1 for 1 cycle, then re-grant to 0001. With the macro undefined, `gnt` stays 0001 indefinitely.
- Reset mid-grant: assert `reset` while `gnt` = 0100 → `gnt` = 0 after the edge, `preempt` = 0, and `ptr` returns to 0.

Source files
------------

// File: rtl/rr_grant_ctrl.sv
// ---------------------------------------------------------------------------
// rr_grant_ctrl
//
// Round-robin grant controller. One shared sequential resource is handed to
// one of N requesters at a time. This is a registered Moore machine. Every
// output is decoded from state registers only, so there is no combinational
// path from req to gnt.
//
// Optional feature macro: RR_GRANT_CTRL_TIMEOUT_EN
//   When this macro is defined, a hold counter limits each grant to MAX_HOLD
//   cycles. A forced release is flagged by a one-cycle preempt pulse.
//   When it is undefined, no counter is built and preempt is tied to 0.
//
// Parameters:
//   N         number of requesters (>= 2)
//   MAX_HOLD  maximum consecutive grant cycles (timeout build only, >= 2)
//   IDW       width of gnt_id, equal to clog2(N)
//
// Ports:
//   clk      in   1    rising-edge clock
//   reset    in   1    synchronous active-high reset
//   req      in   N    request vector, bit i = requester i
//   done     in   1    current owner releases the resource (used in GRANT only)
//   gnt      out  N    one-hot grant, all zeros when there is no owner
//   gnt_id   out  IDW  index of the current or most recent owner
//   busy     out  1    high while a grant is active
//   preempt  out  1    one-cycle pulse after a timeout release
// ---------------------------------------------------------------------------
module rr_grant_ctrl #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic           done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           preempt
);

    // Elaboration-time sanity checks on the parameter set
    if (N < 2) begin : gBadN
        $error("rr_grant_ctrl: N must be at least 2");
    end
    if (MAX_HOLD < 2) begin : gBadMaxHold
        $error("rr_grant_ctrl: MAX_HOLD must be at least 2");
    end
    if (IDW != $clog2(N)) begin : gBadIdw
        $error("rr_grant_ctrl: IDW must equal clog2(N)");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01
    } state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] w_nextPtr;
    logic [IDW-1:0] r_owner;
    logic [IDW-1:0] w_nextOwner;

    logic [2*N-1:0] w_reqDbl;
    logic [N-1:0]   w_reqRot;
    logic           w_anyReq;
    logic [IDW-1:0] w_offset;
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_winner;
    logic           w_ownerReq;
    logic           w_normalRelease;

`ifdef RR_GRANT_CTRL_TIMEOUT_EN
    localparam int HCW = $clog2(MAX_HOLD);

    logic [HCW-1:0] r_holdCnt;
    logic [HCW-1:0] w_nextHoldCnt;
    logic           r_preempt;
    logic           w_nextPreempt;
    logic           w_timeout;
`endif

    // Rotate the request vector right by ptr. Bit 0 of the rotated vector is
    // then the highest-priority requester. The lowest set bit gives the
    // winner's offset from ptr.
    assign w_reqDbl = {req, req} >> r_ptr;
    assign w_reqRot = w_reqDbl[N-1:0];
    assign w_anyReq = |req;

    // Lowest-set-bit priority encoder. The loop runs downward so that the
    // last (lowest) hit wins.
    always_comb begin
        w_offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_reqRot[k]) begin
                w_offset = IDW'(k);
            end
        end
    end

    // Map the offset back to an absolute index modulo N. The extra sum bit
    // keeps the arithmetic correct when N is not a power of two.
    assign w_sum    = {1'b0, r_ptr} + {1'b0, w_offset};
    assign w_winner = (w_sum >= (IDW + 1)'(N)) ? IDW'(w_sum - (IDW + 1)'(N))
                                               : w_sum[IDW-1:0];

    // A voluntary release happens on done or when the owner drops its
    // request. Both together still count as one release.
    assign w_ownerReq      = req[r_owner];
    assign w_normalRelease = done | ~w_ownerReq;

`ifdef RR_GRANT_CTRL_TIMEOUT_EN
    // A timeout counts only when no voluntary release is present, so
    // done-with-timeout stays a normal release and gives no preempt.
    assign w_timeout = (r_holdCnt == HCW'(MAX_HOLD - 1)) & ~w_normalRelease;
`endif

    // Next-state logic. The pointer and owner change only when arbitration
    // succeeds in IDLE. Illegal state encodings fall back to IDLE.
    always_comb begin
        w_nextState = r_state;
        w_nextPtr   = r_ptr;
        w_nextOwner = r_owner;
`ifdef RR_GRANT_CTRL_TIMEOUT_EN
        w_nextHoldCnt = r_holdCnt;
        w_nextPreempt = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_anyReq) begin
                    w_nextState = GRANT;
                    w_nextOwner = w_winner;
                    w_nextPtr   = (w_winner == IDW'(N - 1)) ? '0 : w_winner + 1'b1;
`ifdef RR_GRANT_CTRL_TIMEOUT_EN
                    w_nextHoldCnt = '0;
`endif
                end
            end
            GRANT: begin
`ifdef RR_GRANT_CTRL_TIMEOUT_EN
                w_nextHoldCnt = r_holdCnt + 1'b1;
                if (w_normalRelease) begin
                    w_nextState = IDLE;
                end else if (w_timeout) begin
                    w_nextState   = IDLE;
                    w_nextPreempt = 1'b1;
                end
`else
                if (w_normalRelease) begin
                    w_nextState = IDLE;
                end
`endif
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register. Reset has priority over every other event, including
    // a pending timeout, so a reset never produces a preempt pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
`ifdef RR_GRANT_CTRL_TIMEOUT_EN
            r_holdCnt <= '0;
            r_preempt <= 1'b0;
`endif
        end else begin
            r_state <= w_nextState;
            r_ptr   <= w_nextPtr;
            r_owner <= w_nextOwner;
`ifdef RR_GRANT_CTRL_TIMEOUT_EN
            r_holdCnt <= w_nextHoldCnt;
            r_preempt <= w_nextPreempt;
`endif
        end
    end

    // Output decode. These are pure functions of the registers.
    always_comb begin
        gnt = '0;
        if (r_state == GRANT) begin
            gnt[r_owner] = 1'b1;
        end
    end

    assign busy   = (r_state == GRANT);
    assign gnt_id = r_owner;

`ifdef RR_GRANT_CTRL_TIMEOUT_EN
    assign preempt = r_preempt;
`else
    assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rr_grant_ctrl
//
// Self-checking bench for rr_grant_ctrl with N=4 and MAX_HOLD=8.
// A behavioural model describes the arbiter as "who holds the resource, for
// how many cycles, and where the rotation resumes". The DUT is compared
// against this model on every falling edge. Directed literal checks pin the
// model to hand-computed values from the expected behaviour.
// ---------------------------------------------------------------------------
module tb_rr_grant_ctrl;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;
    localparam int IDW      = 2;

`ifdef RR_GRANT_CTRL_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic           done;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           preempt;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always #5 clk = ~clk;

    rr_grant_ctrl #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD),
        .IDW      (IDW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .preempt (preempt)
    );

    // Behavioural model state
    bit mBusy    = 1'b0;
    int mOwner   = 0;
    int mPtr     = 0;
    int mHeld    = 0;
    bit mPreempt = 1'b0;
    int mPick;
    logic [N-1:0] expGnt;

    // Search for the first requesting index, starting at p and wrapping.
    // Returns -1 when nobody requests.
    function automatic int pickWinner(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Model update on every rising edge, using the inputs present at that edge
    always @(posedge clk) begin
        cycle++;
        if (reset) begin
            mBusy    = 1'b0;
            mOwner   = 0;
            mPtr     = 0;
            mHeld    = 0;
            mPreempt = 1'b0;
        end else if (!mBusy) begin
            mPreempt = 1'b0;
            mPick = pickWinner(req, mPtr);
            if (mPick >= 0) begin
                mBusy  = 1'b1;
                mOwner = mPick;
                mPtr   = (mPick + 1) % N;
                mHeld  = 0;
            end
        end else begin
            mPreempt = 1'b0;
            mHeld    = mHeld + 1;
            if (done || !req[mOwner]) begin
                mBusy = 1'b0;
            end else if (TIMEOUT_ON && mHeld == MAX_HOLD) begin
                mBusy    = 1'b0;
                mPreempt = 1'b1;
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge
    always @(negedge clk) begin
        expGnt = mBusy ? ({{(N-1){1'b0}}, 1'b1} << mOwner) : '0;
        checks++;
        if (gnt !== expGnt || busy !== mBusy || gnt_id !== IDW'(mOwner) || preempt !== mPreempt) begin
            errors++;
            $display("[TB] FAIL model@cycle%0d: got gnt=%b busy=%b id=%0d pre=%b, expected gnt=%b busy=%b id=%0d pre=%b",
                     cycle, gnt, busy, gnt_id, preempt, expGnt, mBusy, mOwner, mPreempt);
        end
    end

    // Drive one cycle of inputs and return at the next falling edge
    task automatic applyStimulus(input logic [N-1:0] r, input logic d, input logic rst);
        req   = r;
        done  = d;
        reset = rst;
        @(negedge clk);
    endtask

    // Compare the DUT outputs against hand-computed literal values
    task automatic checkOutput(input string name, input logic [N-1:0] eG, input logic eB,
                               input logic [IDW-1:0] eI, input logic eP);
        checks++;
        if (gnt !== eG || busy !== eB || gnt_id !== eI || preempt !== eP) begin
            errors++;
            $display("[TB] FAIL %s: got gnt=%b busy=%b id=%0d pre=%b, expected gnt=%b busy=%b id=%0d pre=%b",
                     name, gnt, busy, gnt_id, preempt, eG, eB, eI, eP);
        end
    endtask

    // Keep the run bounded even if the stimulus ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus, followed by a short pseudo-random soak
    logic [N-1:0] rotExp [8];
    logic [IDW-1:0] rotId [8];

    initial begin
        rotExp = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        rotId  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

        // Reset with every requester active
        applyStimulus(4'b1111, 1'b0, 1'b1);
        checkOutput("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        checkOutput("first_grant", 4'b0001, 1'b1, 2'd0, 1'b0);

        // Rotation, with done pulsed one cycle after each grant
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1111, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
            checkOutput($sformatf("rotation_%0d", i), rotExp[i], rotExp[i] != 4'b0000, rotId[i], 1'b0);
        end

        // Move ptr to 3 by granting requester 2, then check skip and wrap
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("ptr_release0", 4'b0000, 1'b0, 2'd0, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("ptr_grant2", 4'b0100, 1'b1, 2'd2, 1'b0);
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("ptr_release2", 4'b0000, 1'b0, 2'd2, 1'b0);
        applyStimulus(4'b0101, 1'b0, 1'b0);
        checkOutput("ptr_wrap_to0", 4'b0001, 1'b1, 2'd0, 1'b0);
        applyStimulus(4'b0101, 1'b1, 1'b0);
        checkOutput("ptr_release_wrap", 4'b0000, 1'b0, 2'd0, 1'b0);
        applyStimulus(4'b0101, 1'b0, 1'b0);
        checkOutput("ptr_skip_to2", 4'b0100, 1'b1, 2'd2, 1'b0);

        // Requests from non-owners are ignored while requester 1 holds the grant
        applyStimulus(4'b0010, 1'b1, 1'b0);
        checkOutput("done_and_drop", 4'b0000, 1'b0, 2'd2, 1'b0);
        applyStimulus(4'b0010, 1'b0, 1'b0);
        checkOutput("grant1", 4'b0010, 1'b1, 2'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus((i % 2 == 0) ? 4'b0110 : 4'b0010, 1'b0, 1'b0);
            checkOutput($sformatf("hold1_%0d", i), 4'b0010, 1'b1, 2'd1, 1'b0);
        end
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("owner_drop", 4'b0000, 1'b0, 2'd1, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("grant2_after_drop", 4'b0100, 1'b1, 2'd2, 1'b0);

        // Reset during a grant. The new grant to 2 proves that ptr is back at 0;
        // a stale ptr of 3 would have chosen requester 3.
        applyStimulus(4'b0100, 1'b0, 1'b1);
        checkOutput("reset_mid_grant", 4'b0000, 1'b0, 2'd0, 1'b0);
        applyStimulus(4'b1100, 1'b0, 1'b0);
        checkOutput("ptr_after_reset", 4'b0100, 1'b1, 2'd2, 1'b0);

        // Long hold by requester 0
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("release_before_hold", 4'b0000, 1'b0, 2'd2, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("hold_cycle1", 4'b0001, 1'b1, 2'd0, 1'b0);
`ifdef RR_GRANT_CTRL_TIMEOUT_EN
        for (int i = 2; i <= MAX_HOLD; i++) begin
            applyStimulus(4'b0001, 1'b0, 1'b0);
            checkOutput($sformatf("hold_cycle%0d", i), 4'b0001, 1'b1, 2'd0, 1'b0);
        end
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("timeout_preempt", 4'b0000, 1'b0, 2'd0, 1'b1);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("regrant_after_timeout", 4'b0001, 1'b1, 2'd0, 1'b0);
        for (int i = 2; i < MAX_HOLD; i++) begin
            applyStimulus(4'b0001, 1'b0, 1'b0);
        end
        applyStimulus(4'b0001, 1'b1, 1'b0);
        checkOutput("done_with_timeout", 4'b0000, 1'b0, 2'd0, 1'b0);
`else
        for (int i = 2; i <= 12; i++) begin
            applyStimulus(4'b0001, 1'b0, 1'b0);
            checkOutput($sformatf("hold_cycle%0d", i), 4'b0001, 1'b1, 2'd0, 1'b0);
        end
`endif
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("final_release", 4'b0000, 1'b0, 2'd0, 1'b0);

        // Pseudo-random soak, checked by the model process
        for (int i = 0; i < 400; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
                          $urandom_range(0, 80) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
